// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the boot-time instruction memory loader.
//   loader_state_e   : loader FSM states
//   CNT_W            : width of the image word-count header field
//   BYTES_PER_WORD   : bytes packed into one IMEM word
//   BOOT_ADDR        : first IMEM word address written by every load
//   is_accepting()   : true in the states that take stream bytes
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int CNT_W          = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int BOOT_ADDR      = 0;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_e;

    // The byte stream is only consumed while a load is in progress.
    function automatic logic is_accepting(input loader_state_e state);
        return (state == HDR0) || (state == HDR1) ||
               (state == DATA) || (state == CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// ---------------------------------------------------------------------------
// word_packer
// Collects bytes little-endian into a 32-bit word. The first byte of a word
// lands in bits 7:0. On the fourth byte the completed word is presented
// combinationally on word_o together with a one-cycle word_valid_o, so the
// caller can register it on the same edge that accepts that byte.
// Ports:
//   clk_i        : clock
//   clear_i      : synchronous clear of the byte index and partial word
//   byte_valid_i : byte_i is consumed on this edge
//   byte_i       : incoming byte
//   word_o       : assembled word (meaningful only with word_valid_o)
//   word_valid_o : byte_i completes a word this cycle
// ---------------------------------------------------------------------------
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam int IDX_W   = $clog2(BYTES_PER_WORD);
    localparam int SHIFT_W = 8 * (BYTES_PER_WORD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [SHIFT_W-1:0] shift_q;
    logic [SHIFT_W-1:0] shift_d;

    // Newer bytes enter at the top and slide down, so after three bytes the
    // oldest sits in the low lane and the fourth byte tops off the word.
    always_comb begin
        idx_d        = idx_q;
        shift_d      = shift_q;
        word_o       = {byte_i, shift_q};
        word_valid_o = byte_valid_i && (idx_q == LAST_IDX);
        if (byte_valid_i) begin
            shift_d = {byte_i, shift_q[SHIFT_W-1:8]};
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Byte index and partial word; clear restarts packing on a word boundary.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot stage in front of the RV32I core. Receives a program image as a byte
// stream (CNT_LO, CNT_HI, 4*N data bytes LSB first, CSUM), writes the words
// sequentially into IMEM from BOOT_ADDR, and releases the core from reset only
// when the XOR checksum of header and data bytes matches CSUM.
// Ports:
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   start      : one-cycle pulse starting a load (from IDLE, DONE or ERR)
//   in_valid   : in_data carries a byte
//   in_data    : image byte
//   in_ready   : loader accepts a byte this cycle
//   imem_we    : one-cycle IMEM write strobe per word
//   imem_addr  : IMEM word address (holds between writes)
//   imem_wdata : IMEM write data
//   core_rst   : core reset, high until a load succeeds
//   load_done  : image loaded and checksum verified
//   load_err   : load aborted (oversized count or bad checksum)
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err
);

    // One extra bit so a full 2^ADDR_W image is representable.
    localparam logic [CNT_W:0] CAPACITY = (CNT_W + 1)'(2 ** ADDR_W);

    loader_state_e      state_q,      state_d;
    logic [7:0]         cntLo_q,      cntLo_d;
    logic [CNT_W-1:0]   count_q,      count_d;
    logic [CNT_W-1:0]   wordIdx_q,    wordIdx_d;
    logic [7:0]         csum_q,       csum_d;
    logic               imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0]  imem_addr_q,  imem_addr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
    logic               core_rst_q,   core_rst_d;
    logic               load_done_q,  load_done_d;
    logic               load_err_q,   load_err_d;

    logic               accept;
    logic               startTake;
    logic [CNT_W-1:0]   hdrCount;
    logic [31:0]        packWord;
    logic               packWordValid;

    assign in_ready   = is_accepting(state_q);
    assign accept     = in_valid && in_ready;
    assign hdrCount   = {in_data, cntLo_q};

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

    word_packer u_packer (
        .clk_i        (CLK),
        .clear_i      (RST || startTake),
        .byte_valid_i (accept && (state_q == DATA)),
        .byte_i       (in_data),
        .word_o       (packWord),
        .word_valid_o (packWordValid)
    );

    // Loader sequencing: header parse, word writes, checksum verdict.
    // imem_we is a pulse, so it falls back to 0 unless a word completes.
    always_comb begin
        state_d      = state_q;
        cntLo_d      = cntLo_q;
        count_d      = count_q;
        wordIdx_d    = wordIdx_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_rst_d   = core_rst_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;
        startTake    = 1'b0;

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    startTake   = 1'b1;
                    state_d     = HDR0;
                    core_rst_d  = 1'b1;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    imem_addr_d = ADDR_W'(BOOT_ADDR);
                    wordIdx_d   = '0;
                    count_d     = '0;
                    csum_d      = '0;
                end
            end
            HDR0: begin
                if (accept) begin
                    cntLo_d = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    count_d = hdrCount;
                    csum_d  = csum_q ^ in_data;
                    if ({1'b0, hdrCount} > CAPACITY) begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                    end else if (hdrCount == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    if (packWordValid) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = wordIdx_q[ADDR_W-1:0];
                        imem_wdata_d = packWord;
                        wordIdx_d    = wordIdx_q + CNT_W'(1);
                        if (wordIdx_q == count_q - CNT_W'(1)) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d     = DONE;
                        core_rst_d  = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; RST dominates a coincident start.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cntLo_q      <= '0;
            count_q      <= '0;
            wordIdx_q    <= '0;
            csum_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cntLo_q      <= cntLo_d;
            count_q      <= count_d;
            wordIdx_q    <= wordIdx_d;
            csum_q       <= csum_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Images are parsed by a reference model
// that pushes the expected IMEM writes into a queue; a negedge monitor pops
// and compares each write the DUT issues. Final status is compared after the
// last byte of each image.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              load_done;
    logic              load_err;

    int errors = 0;
    int checks = 0;

    logic [7:0]          txBytes[$];
    logic [ADDR_W+31:0]  expWrites[$];
    logic [ADDR_W+31:0]  monExp;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 CLK = ~CLK;

    // Safety net: a hung run still reports and stops.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Write monitor: every IMEM strobe must match the next expected write.
    always @(negedge CLK) begin
        if (imem_we === 1'b1) begin
            if (expWrites.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected write: got addr 0x%0h data 0x%0h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                monExp = expWrites.pop_front();
                checkOutput("write addr", 32'(imem_addr), 32'(monExp[ADDR_W+31:32]));
                checkOutput("write data", imem_wdata, monExp[31:0]);
            end
        end
    end

    // Reference model: parses the first nBytes of txBytes by the image rules.
    // outcome: 0 = not finished, 1 = verified, 2 = aborted.
    task automatic modelImage(input int nBytes, output int outcome, output int lastAddr);
        int         n;
        logic [7:0] x;
        outcome  = 0;
        lastAddr = 0;
        if (nBytes < 2) return;
        n = int'({txBytes[1], txBytes[0]});
        x = txBytes[0] ^ txBytes[1];
        if (n > (1 << ADDR_W)) begin
            outcome = 2;
            return;
        end
        for (int w = 0; w < n; w++) begin
            if (2 + 4 * w + 3 < nBytes)
                expWrites.push_back({ADDR_W'(w), txBytes[2 + 4 * w + 3], txBytes[2 + 4 * w + 2],
                                     txBytes[2 + 4 * w + 1], txBytes[2 + 4 * w]});
            for (int k = 0; k < 4; k++)
                if (2 + 4 * w + k < nBytes) x = x ^ txBytes[2 + 4 * w + k];
        end
        if (n > 0) lastAddr = n - 1;
        if (nBytes > 2 + 4 * n) outcome = (txBytes[2 + 4 * n] == x) ? 1 : 2;
    endtask

    // Streams the first nBytes of txBytes, with random idle gaps between bytes.
    // Entered and left on a negedge; on return the last byte has been accepted.
    task automatic applyStimulus(input int nBytes, input int gapMin, input int gapMax);
        int guard;
        int gap;
        for (int i = 0; i < nBytes; i++) begin
            in_valid = 1'b1;
            in_data  = txBytes[i];
            guard    = 0;
            while (in_ready !== 1'b1 && guard < 50) begin
                @(negedge CLK);
                guard++;
            end
            if (guard >= 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL handshake timeout at byte %0d: got in_ready=0, expected 1", i);
                in_valid = 1'b0;
                return;
            end
            @(negedge CLK);
            in_valid = 1'b0;
            if (i != nBytes - 1) begin
                gap = $urandom_range(gapMax, gapMin);
                for (int g = 0; g < gap; g++) begin
                    checkOutput("ready during stall", 32'(in_ready), 32'd1);
                    @(negedge CLK);
                end
            end
        end
    endtask

    task automatic startLoad();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checkOutput("ready after start", 32'(in_ready), 32'd1);
    endtask

    task automatic checkReset();
        checkOutput("reset in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset imem_we", 32'(imem_we), 32'd0);
        checkOutput("reset imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("reset imem_wdata", imem_wdata, 32'd0);
        checkOutput("reset core_rst", 32'(core_rst), 32'd1);
        checkOutput("reset load_done", 32'(load_done), 32'd0);
        checkOutput("reset load_err", 32'(load_err), 32'd0);
    endtask

    task automatic checkFinal(input int outcome, input int lastAddr);
        checkOutput("final load_done", 32'(load_done), (outcome == 1) ? 32'd1 : 32'd0);
        checkOutput("final load_err", 32'(load_err), (outcome == 2) ? 32'd1 : 32'd0);
        checkOutput("final core_rst", 32'(core_rst), (outcome == 1) ? 32'd0 : 32'd1);
        checkOutput("final in_ready", 32'(in_ready), 32'd0);
        checkOutput("final imem_addr", 32'(imem_addr), 32'(lastAddr));
        checkOutput("pending writes", 32'(expWrites.size()), 32'd0);
    endtask

    task automatic runImage(input int gapMin, input int gapMax);
        int outcome;
        int lastAddr;
        startLoad();
        modelImage(txBytes.size(), outcome, lastAddr);
        applyStimulus(txBytes.size(), gapMin, gapMax);
        checkFinal(outcome, lastAddr);
    endtask

    task automatic buildImage(input int n, input bit badCsum);
        logic [7:0] x;
        logic [7:0] b;
        txBytes.delete();
        txBytes.push_back(n[7:0]);
        txBytes.push_back(n[15:8]);
        x = n[7:0] ^ n[15:8];
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom_range(255, 0));
            txBytes.push_back(b);
            x = x ^ b;
        end
        if (badCsum) x = x ^ 8'($urandom_range(255, 1));
        txBytes.push_back(x);
    endtask

    task automatic loadTwoWord();
        txBytes = {8'h02, 8'h00, 8'hB3, 8'h82, 8'h20, 8'h00,
                   8'h33, 8'h83, 8'h41, 8'h40, 8'hA2};
    endtask

    initial begin
        int outcome;
        int lastAddr;
        int n;
        RST      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge CLK);
        checkReset();
        RST = 1'b0;
        @(negedge CLK);

        $display("[TB] two-word image");
        loadTwoWord();
        runImage(0, 0);

        $display("[TB] two-word image with bad checksum");
        loadTwoWord();
        txBytes[10] = 8'hA3;
        runImage(0, 0);

        $display("[TB] empty image");
        txBytes = {8'h00, 8'h00, 8'h00};
        runImage(0, 0);

        $display("[TB] oversized count");
        txBytes = {8'h01, 8'h01};
        runImage(0, 0);

        $display("[TB] two-word image with stalls");
        loadTwoWord();
        runImage(3, 3);

        $display("[TB] reset mid-load");
        loadTwoWord();
        startLoad();
        modelImage(6, outcome, lastAddr);
        applyStimulus(6, 0, 0);
        RST = 1'b1;
        @(negedge CLK);
        checkReset();
        RST = 1'b0;
        checkOutput("pending writes after reset", 32'(expWrites.size()), 32'd0);
        @(negedge CLK);
        runImage(0, 0);

        $display("[TB] reset and start together");
        RST   = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        RST   = 1'b0;
        start = 1'b0;
        checkReset();
        @(negedge CLK);
        checkOutput("idle after reset", 32'(in_ready), 32'd0);

        $display("[TB] full-capacity image");
        buildImage(1 << ADDR_W, 1'b0);
        runImage(0, 0);

        $display("[TB] randomized images");
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(7, 0) == 0) begin
                n = $urandom_range(65535, (1 << ADDR_W) + 1);
                txBytes.delete();
                txBytes.push_back(n[7:0]);
                txBytes.push_back(n[15:8]);
            end else begin
                buildImage($urandom_range(6, 0), $urandom_range(3, 0) == 0);
            end
            runImage(0, 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Upstream boot stage for the pipelined RV32I core. It receives a program image as a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and writes them sequentially into instruction memory through the IMEM write port. It holds the core in reset until a complete image with a correct checksum has been written, then releases it.

Parameters:
ADDR_W, 8, IMEM word-address width; capacity is 2^ADDR_W words.

Ports:
CLK  input  1  system clock; all logic on the rising edge
RST  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse that begins a load
in_valid  input  1  in_data holds a byte
in_data  input  8  image byte
in_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  IMEM write strobe, one cycle per word
imem_addr  output  ADDR_W  IMEM word address
imem_wdata  output  32  IMEM write data
core_rst  output  1  reset to the core; high until a load succeeds
load_done  output  1  image loaded and verified
load_err  output  1  load aborted

Behaviour:
- Image format: CNT_LO, CNT_HI (16-bit word count N), then 4*N data bytes with each word LSB first, then one CSUM byte. CSUM is the XOR of every header and data byte.
- A byte is accepted in a cycle where in_valid && in_ready.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, load_done=0, load_err=0. State is IDLE, and the word counter, byte index and checksum accumulator are 0.
- States: IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR.
- in_ready=1 only in HDR0, HDR1, DATA and CSUM. It is a combinational decode of state.
- start is honoured in IDLE, DONE and ERR. On the next edge:
  - state=HDR0, core_rst=1, load_done=0, load_err=0
  - address, counter and checksum cleared
  - start is ignored in all other states.
- HDR0 accepts a byte, latches CNT_LO and moves to HDR1.
- HDR1 accepts a byte and forms N, then:
  - N > 2^ADDR_W: go to ERR.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA accepts bytes and shifts them into a word register, byte index 0..3.
  - On the 4th byte, the next edge asserts imem_we=1 for exactly one cycle, with imem_wdata = assembled word and imem_addr = current word index.
  - The word index then increments.
  - After word N-1 the state goes to CSUM. The last write strobe coincides with the first CSUM cycle.
- CSUM accepts a byte.
  - If it equals the accumulator: next edge state=DONE, core_rst=0, load_done=1.
  - Otherwise: state=ERR, load_err=1, core_rst stays 1.
- The checksum accumulator XORs each accepted header and data byte, never the CSUM byte.
- DONE and ERR are sticky until start or RST.
- imem_addr holds its last value when imem_we=0. It never wraps, because N ≤ 2^ADDR_W; after word 2^ADDR_W−1 no further increment is used.
- Stalls: in_valid=0 in any accepting state holds all state; there is no timeout.
- RST mid-load returns to IDLE with reset values on the next edge. IMEM contents already written are not erased, and the core stays in reset.
- Simultaneous RST and start: RST wins.

Decomposition:
- Package imem_loader_pkg:
  - state enum
  - CNT_W=16
  - BYTES_PER_WORD=4
  - constant BOOT_ADDR=0
- Sub-module word_packer:
  - shifts in 8-bit bytes and emits a 32-bit word plus a word_valid pulse on the 4th byte
  - has a clear input driven on start/RST
- The top level keeps the FSM, counters, checksum and handshake.

Test Plan:
- Two-word load. Stream 02 00 B3 82 20 00 33 83 41 40 A2 with in_valid held high.
  - Writes 0x002082B3 to addr 0 and 0x40418333 to addr 1.
  - load_done=1 and core_rst=0 one cycle after byte A2 is accepted.
- Same stream with CSUM=A3: both words are written, then load_err=1, core_rst stays 1, in_ready=0.
- N=0: stream 00 00 00. No imem_we pulses; load_done=1.
- ADDR_W=8, count 0x0101 (bytes 01 01): ERR right after HDR1, no writes, in_ready=0.
- Two-word stream with in_valid deasserted for 3 cycles between each byte: identical writes and result; in_ready stays 1 throughout.
- RST asserted after the 6th byte:
  - all outputs return to reset values; word 0 remains in IMEM
  - a new start plus a full stream then completes normally.
